// File: rtl/rd_pair_sequencer.sv
// Purpose: turns a {k,l} lookup pair into two back-to-back TX_RD reads and re-pairs the in-order RX_RD beats.
// Latency: k request 1 cycle after accept, l request 1 cycle later; resp_valid 1 cycle after the second beat.
// Backpressure: pair_ready drops on almostfull, in ISSUE_L, or at MAX_OUT pairs outstanding; almostfull stalls the l request.
// Optional: RD_PAIR_DEDUP_EN issues a single read when k==l and answers that pair with one beat.
module rd_pair_sequencer #(
   parameter int ADDR_W  = 58,
   parameter int DATA_W  = 512,
   parameter int MAX_OUT = 8,
   parameter int CNT_W   = 4
) (
   input  logic              CLK_400M,
   input  logic              spl_reset,
   input  logic              pair_valid,
   output logic              pair_ready,
   input  logic [ADDR_W-1:0] pair_addr_k,
   input  logic [ADDR_W-1:0] pair_addr_l,
   input  logic              spl_tx_rd_almostfull,
   output logic              cor_tx_rd_valid,
   output logic [ADDR_W-1:0] cor_tx_rd_addr,
   input  logic              io_rx_rd_valid,
   input  logic [DATA_W-1:0] io_rx_data,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_data_k,
   output logic [DATA_W-1:0] resp_data_l,
   output logic [CNT_W-1:0]  outstanding,
   output logic              err_orphan
);

   typedef enum logic {IDLE, ISSUE_L} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_l_q, addr_l_d;
   logic                tx_vld_q, tx_vld_d;
   logic [ADDR_W-1:0]   tx_addr_q, tx_addr_d;
   logic                phase_q, phase_d;
   logic [CNT_W-1:0]    out_q, out_d;
   logic                resp_vld_q, resp_vld_d;
   logic [DATA_W-1:0]   data_k_q, data_k_d;
   logic [DATA_W-1:0]   data_l_q, data_l_d;
   logic                orphan_q, orphan_d;

   logic                accept;
   logic                complete;
   logic                dedup_hit;

   assign pair_ready = (state_q == IDLE) && !spl_tx_rd_almostfull
                       && (out_q < CNT_W'(MAX_OUT));
   assign accept     = pair_valid && pair_ready;

`ifdef RD_PAIR_DEDUP_EN
   localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

   // One flag per outstanding pair, in issue order; the head belongs to the pair the next beat answers.
   logic [MAX_OUT-1:0]  flag_q, flag_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic                head_dedup;

   assign dedup_hit  = (pair_addr_k == pair_addr_l);
   assign head_dedup = flag_q[rd_ptr_q];

   // Flag FIFO: push on accept, pop on completion; outstanding doubles as its occupancy.
   always_comb begin
      flag_d   = flag_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (accept) begin
         flag_d[wr_ptr_q] = dedup_hit;
         wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (complete) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
   end

   // Flag FIFO registers.
   always_ff @(posedge CLK_400M) begin
      if (spl_reset) begin
         flag_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         flag_q   <= flag_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end
`else
   assign dedup_hit = 1'b0;
`endif

   // Issue FSM: k goes out the cycle after accept, l follows as soon as almostfull allows.
   always_comb begin
      state_d   = state_q;
      addr_l_d  = addr_l_q;
      tx_vld_d  = 1'b0;
      tx_addr_d = tx_addr_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               tx_vld_d  = 1'b1;
               tx_addr_d = pair_addr_k;
               addr_l_d  = pair_addr_l;
               if (!dedup_hit) begin
                  state_d = ISSUE_L;
               end
            end
         end
         ISSUE_L: begin
            if (!spl_tx_rd_almostfull) begin
               tx_vld_d  = 1'b1;
               tx_addr_d = addr_l_q;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // RX pairing: beats arrive in order, phase 0 is k and phase 1 is l; a beat with nothing outstanding is dropped.
   always_comb begin
      phase_d    = phase_q;
      data_k_d   = data_k_q;
      data_l_d   = data_l_q;
      resp_vld_d = 1'b0;
      orphan_d   = orphan_q;
      complete   = 1'b0;
      if (io_rx_rd_valid) begin
         if (!phase_q) begin
            if (out_q == '0) begin
               orphan_d = 1'b1;
            end
`ifdef RD_PAIR_DEDUP_EN
            else if (head_dedup) begin
               data_k_d   = io_rx_data;
               data_l_d   = io_rx_data;
               resp_vld_d = 1'b1;
               complete   = 1'b1;
            end
`endif
            else begin
               data_k_d = io_rx_data;
               phase_d  = 1'b1;
            end
         end else begin
            data_l_d   = io_rx_data;
            phase_d    = 1'b0;
            resp_vld_d = 1'b1;
            complete   = 1'b1;
         end
      end
   end

   // Outstanding pair count; pair_ready gating keeps it from passing MAX_OUT.
   always_comb begin
      out_d = out_q;
      case ({accept, complete})
         2'b10:   out_d = out_q + CNT_W'(1);
         2'b01:   out_d = out_q - CNT_W'(1);
         default: out_d = out_q;
      endcase
   end

   // FSM state register.
   always_ff @(posedge CLK_400M) begin
      if (spl_reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath and status registers; reset drops any in-flight pair and partial response.
   always_ff @(posedge CLK_400M) begin
      if (spl_reset) begin
         addr_l_q   <= '0;
         tx_vld_q   <= 1'b0;
         tx_addr_q  <= '0;
         phase_q    <= 1'b0;
         out_q      <= '0;
         resp_vld_q <= 1'b0;
         data_k_q   <= '0;
         data_l_q   <= '0;
         orphan_q   <= 1'b0;
      end else begin
         addr_l_q   <= addr_l_d;
         tx_vld_q   <= tx_vld_d;
         tx_addr_q  <= tx_addr_d;
         phase_q    <= phase_d;
         out_q      <= out_d;
         resp_vld_q <= resp_vld_d;
         data_k_q   <= data_k_d;
         data_l_q   <= data_l_d;
         orphan_q   <= orphan_d;
      end
   end

   assign cor_tx_rd_valid = tx_vld_q;
   assign cor_tx_rd_addr  = tx_addr_q;
   assign resp_valid      = resp_vld_q;
   assign resp_data_k     = data_k_q;
   assign resp_data_l     = data_l_q;
   assign outstanding     = out_q;
   assign err_orphan      = orphan_q;

endmodule

// File: tb/tb_rd_pair_sequencer.sv
`timescale 1ns/1ps
module tb_rd_pair_sequencer;

   localparam int ADDR_W = 58;
   localparam int DATA_W = 512;

   logic              clk;
   logic              spl_reset;
   logic              pair_valid;
   logic              pair_ready;
   logic [ADDR_W-1:0] pair_addr_k;
   logic [ADDR_W-1:0] pair_addr_l;
   logic              spl_tx_rd_almostfull;
   logic              cor_tx_rd_valid;
   logic [ADDR_W-1:0] cor_tx_rd_addr;
   logic              io_rx_rd_valid;
   logic [DATA_W-1:0] io_rx_data;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_data_k;
   logic [DATA_W-1:0] resp_data_l;
   logic [3:0]        outstanding;
   logic              err_orphan;

   int n_cmp = 0;
   int n_bad = 0;

   rd_pair_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(8), .CNT_W(4)) dut (
      .CLK_400M             (clk),
      .spl_reset            (spl_reset),
      .pair_valid           (pair_valid),
      .pair_ready           (pair_ready),
      .pair_addr_k          (pair_addr_k),
      .pair_addr_l          (pair_addr_l),
      .spl_tx_rd_almostfull (spl_tx_rd_almostfull),
      .cor_tx_rd_valid      (cor_tx_rd_valid),
      .cor_tx_rd_addr       (cor_tx_rd_addr),
      .io_rx_rd_valid       (io_rx_rd_valid),
      .io_rx_data           (io_rx_data),
      .resp_valid           (resp_valid),
      .resp_data_k          (resp_data_k),
      .resp_data_l          (resp_data_l),
      .outstanding          (outstanding),
      .err_orphan           (err_orphan)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic              rst, pv;
      logic [ADDR_W-1:0] ak, al;
      logic              af, rv;
      logic [DATA_W-1:0] rd;
      logic              e_rdy, e_txv;
      logic [ADDR_W-1:0] e_txa;
      logic              e_rspv;
      logic [DATA_W-1:0] e_k, e_l;
      logic [3:0]        e_out;
      logic              e_err;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [DATA_W-1:0] dat(input logic [31:0] s);
      return {16{s}};
   endfunction

   function automatic vec_t mk(input logic rst, input logic pv, input logic [ADDR_W-1:0] ak,
                               input logic [ADDR_W-1:0] al, input logic af, input logic rv,
                               input logic [DATA_W-1:0] rd, input logic e_rdy, input logic e_txv,
                               input logic [ADDR_W-1:0] e_txa, input logic e_rspv,
                               input logic [DATA_W-1:0] e_k, input logic [DATA_W-1:0] e_l,
                               input logic [3:0] e_out, input logic e_err);
      vec_t v;
      v.rst = rst; v.pv = pv; v.ak = ak; v.al = al; v.af = af; v.rv = rv; v.rd = rd;
      v.e_rdy = e_rdy; v.e_txv = e_txv; v.e_txa = e_txa; v.e_rspv = e_rspv;
      v.e_k = e_k; v.e_l = e_l; v.e_out = e_out; v.e_err = e_err;
      return v;
   endfunction

   task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      pair_valid           = 1'b0;
      pair_addr_k          = '0;
      pair_addr_l          = '0;
      spl_tx_rd_almostfull = 1'b0;
      io_rx_rd_valid       = 1'b0;
      io_rx_data           = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      spl_reset = 1'b1;
      @(negedge clk);
      spl_reset = 1'b0;
   endtask

   task automatic apply_vec(input vec_t v, input int idx);
      @(negedge clk);
      spl_reset            = v.rst;
      pair_valid           = v.pv;
      pair_addr_k          = v.ak;
      pair_addr_l          = v.al;
      spl_tx_rd_almostfull = v.af;
      io_rx_rd_valid       = v.rv;
      io_rx_data           = v.rd;
      #1;
      check($sformatf("v%0d pair_ready", idx), pair_ready, v.e_rdy);
      @(posedge clk);
      #1;
      check($sformatf("v%0d tx_valid", idx), cor_tx_rd_valid, v.e_txv);
      if (v.e_txv || v.rst) check($sformatf("v%0d tx_addr", idx), cor_tx_rd_addr, v.e_txa);
      check($sformatf("v%0d resp_valid", idx), resp_valid, v.e_rspv);
      if (v.e_rspv || v.rst) begin
         check($sformatf("v%0d resp_k", idx), resp_data_k, v.e_k);
         check($sformatf("v%0d resp_l", idx), resp_data_l, v.e_l);
      end
      check($sformatf("v%0d outstanding", idx), outstanding, v.e_out);
      check($sformatf("v%0d err_orphan", idx), err_orphan, v.e_err);
   endtask

   initial begin
      int idx;
      int ntx;
      logic acc;
      logic [ADDR_W-1:0] got_tx[$];
      logic [ADDR_W-1:0] exp_tx[$];
      logic [DATA_W-1:0] got_k[$], got_l[$];
      logic [DATA_W-1:0] exp_k[$], exp_l[$];
      logic [ADDR_W-1:0] pk[2], pl[2];
      logic [DATA_W-1:0] beats[$];

      idle_inputs();
      spl_reset = 1'b1;
      repeat (2) @(posedge clk);

      //                 rst pv  ak     al     af rv rd          rdy txv txa    rspv k           l           out err
      tbl.push_back(mk(1, 0, 0,     0,     0, 0, 0,           1, 0, 0,     0, 0,          0,          0, 0)); // v0 reset
      tbl.push_back(mk(0, 1, 'h100, 'h2A3, 0, 0, 0,           1, 1, 'h100, 0, 0,          0,          1, 0)); // v1
      tbl.push_back(mk(0, 0, 0,     0,     0, 0, 0,           0, 1, 'h2A3, 0, 0,          0,          1, 0)); // v2
      tbl.push_back(mk(0, 0, 0,     0,     0, 1, dat('hD0),   1, 0, 0,     0, 0,          0,          1, 0)); // v3
      tbl.push_back(mk(0, 0, 0,     0,     0, 1, dat('hD1),   1, 0, 0,     1, dat('hD0),  dat('hD1),  0, 0)); // v4
      tbl.push_back(mk(0, 0, 0,     0,     0, 0, 0,           1, 0, 0,     0, 0,          0,          0, 0)); // v5
      tbl.push_back(mk(0, 1, 'h40,  'h41,  0, 0, 0,           1, 1, 'h40,  0, 0,          0,          1, 0)); // v6
      tbl.push_back(mk(0, 1, 'h40,  'h41,  1, 0, 0,           0, 0, 0,     0, 0,          0,          1, 0)); // v7 af
      tbl.push_back(mk(0, 1, 'h40,  'h41,  1, 0, 0,           0, 0, 0,     0, 0,          0,          1, 0)); // v8 af
      tbl.push_back(mk(0, 1, 'h40,  'h41,  1, 0, 0,           0, 0, 0,     0, 0,          0,          1, 0)); // v9 af
      tbl.push_back(mk(0, 0, 0,     0,     0, 0, 0,           0, 1, 'h41,  0, 0,          0,          1, 0)); // v10
      tbl.push_back(mk(0, 0, 0,     0,     0, 0, 0,           1, 0, 0,     0, 0,          0,          1, 0)); // v11
      tbl.push_back(mk(0, 0, 0,     0,     0, 1, dat('hE0),   1, 0, 0,     0, 0,          0,          1, 0)); // v12
      tbl.push_back(mk(0, 0, 0,     0,     0, 1, dat('hE1),   1, 0, 0,     1, dat('hE0),  dat('hE1),  0, 0)); // v13
      tbl.push_back(mk(0, 1, 'h1,   'h2,   0, 0, 0,           1, 1, 'h1,   0, 0,          0,          1, 0)); // v14
      tbl.push_back(mk(0, 0, 0,     0,     0, 0, 0,           0, 1, 'h2,   0, 0,          0,          1, 0)); // v15
      tbl.push_back(mk(0, 1, 'h3,   'h4,   0, 0, 0,           1, 1, 'h3,   0, 0,          0,          2, 0)); // v16
      tbl.push_back(mk(0, 0, 0,     0,     0, 0, 0,           0, 1, 'h4,   0, 0,          0,          2, 0)); // v17
      tbl.push_back(mk(0, 1, 'h5,   'h6,   0, 0, 0,           1, 1, 'h5,   0, 0,          0,          3, 0)); // v18
      tbl.push_back(mk(0, 0, 0,     0,     0, 0, 0,           0, 1, 'h6,   0, 0,          0,          3, 0)); // v19
      tbl.push_back(mk(0, 0, 0,     0,     0, 1, dat('hF0),   1, 0, 0,     0, 0,          0,          3, 0)); // v20
      tbl.push_back(mk(0, 1, 'h7,   'h8,   0, 1, dat('hF1),   1, 1, 'h7,   1, dat('hF0),  dat('hF1),  3, 0)); // v21 inc+dec
      tbl.push_back(mk(0, 0, 0,     0,     0, 0, 0,           0, 1, 'h8,   0, 0,          0,          3, 0)); // v22
      tbl.push_back(mk(0, 0, 0,     0,     0, 1, dat('hA0),   1, 0, 0,     0, 0,          0,          3, 0)); // v23
      tbl.push_back(mk(0, 0, 0,     0,     0, 1, dat('hA1),   1, 0, 0,     1, dat('hA0),  dat('hA1),  2, 0)); // v24
      tbl.push_back(mk(0, 0, 0,     0,     0, 1, dat('hA2),   1, 0, 0,     0, 0,          0,          2, 0)); // v25
      tbl.push_back(mk(0, 0, 0,     0,     0, 1, dat('hA3),   1, 0, 0,     1, dat('hA2),  dat('hA3),  1, 0)); // v26
      tbl.push_back(mk(0, 0, 0,     0,     0, 1, dat('hA4),   1, 0, 0,     0, 0,          0,          1, 0)); // v27
      tbl.push_back(mk(0, 0, 0,     0,     0, 1, dat('hA5),   1, 0, 0,     1, dat('hA4),  dat('hA5),  0, 0)); // v28
      tbl.push_back(mk(0, 0, 0,     0,     0, 1, dat('hB0),   1, 0, 0,     0, 0,          0,          0, 1)); // v29 orphan
      tbl.push_back(mk(0, 0, 0,     0,     0, 1, dat('hB1),   1, 0, 0,     0, 0,          0,          0, 1)); // v30 orphan
      tbl.push_back(mk(0, 0, 0,     0,     0, 0, 0,           1, 0, 0,     0, 0,          0,          0, 1)); // v31 sticky
      tbl.push_back(mk(0, 1, 'h77,  'h78,  0, 0, 0,           1, 1, 'h77,  0, 0,          0,          1, 1)); // v32
      tbl.push_back(mk(1, 0, 0,     0,     0, 0, 0,           0, 0, 0,     0, 0,          0,          0, 0)); // v33 reset in ISSUE_L
      tbl.push_back(mk(0, 0, 0,     0,     0, 0, 0,           1, 0, 0,     0, 0,          0,          0, 0)); // v34 l never issued
      tbl.push_back(mk(0, 0, 0,     0,     0, 1, dat('hC0),   1, 0, 0,     0, 0,          0,          0, 1)); // v35 orphan after reset
      tbl.push_back(mk(0, 0, 0,     0,     0, 0, 0,           1, 0, 0,     0, 0,          0,          0, 1)); // v36

      foreach (tbl[i]) apply_vec(tbl[i], i);

      // Saturation: 10 pairs offered back to back with no returns; only 8 fit.
      do_reset();
      idx = 0;
      ntx = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         pair_valid  = (idx < 10);
         pair_addr_k = ADDR_W'('h200 + 2 * idx);
         pair_addr_l = ADDR_W'('h201 + 2 * idx);
         #1;
         acc = pair_valid && pair_ready;
         @(posedge clk);
         if (acc) idx++;
         #1;
         if (cor_tx_rd_valid) begin
            check($sformatf("sat tx%0d addr", ntx), cor_tx_rd_addr, ADDR_W'('h200 + ntx));
            ntx++;
         end
      end
      check("sat accepted", idx, 8);
      check("sat tx count", ntx, 16);
      check("sat outstanding", outstanding, 4'd8);
      @(negedge clk);
      pair_valid     = 1'b1;
      io_rx_rd_valid = 1'b1;
      io_rx_data     = dat('h5A0);
      #1;
      check("sat ready held low", pair_ready, 1'b0);
      @(posedge clk); #1;
      check("sat out after k beat", outstanding, 4'd8);
      @(negedge clk);
      io_rx_data = dat('h5A1);
      @(posedge clk); #1;
      check("sat out after return", outstanding, 4'd7);
      check("sat resp_valid", resp_valid, 1'b1);
      check("sat resp_k", resp_data_k, dat('h5A0));
      check("sat resp_l", resp_data_l, dat('h5A1));
      @(negedge clk);
      io_rx_rd_valid = 1'b0;
      #1;
      check("sat ready reopens", pair_ready, 1'b1);
      @(posedge clk); #1;
      check("sat out refilled", outstanding, 4'd8);
      check("sat ninth k valid", cor_tx_rd_valid, 1'b1);
      check("sat ninth k addr", cor_tx_rd_addr, ADDR_W'('h210));
      @(negedge clk);
      pair_valid = 1'b0;
      @(posedge clk); #1;
      check("sat ninth l addr", cor_tx_rd_addr, ADDR_W'('h211));

      // Equal-address pair followed by a normal pair.
      do_reset();
      pk[0] = 'h55; pl[0] = 'h55;
      pk[1] = 'h10; pl[1] = 'h11;
      idx = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         pair_valid  = (idx < 2);
         pair_addr_k = (idx < 2) ? pk[idx] : '0;
         pair_addr_l = (idx < 2) ? pl[idx] : '0;
         #1;
         acc = pair_valid && pair_ready;
         @(posedge clk);
         if (acc) idx++;
         #1;
         if (cor_tx_rd_valid) got_tx.push_back(cor_tx_rd_addr);
      end
`ifdef RD_PAIR_DEDUP_EN
      exp_tx = '{'h55, 'h10, 'h11};
      beats  = '{dat('hAAAA), dat('hBBBB), dat('hCCCC)};
      exp_k  = '{dat('hAAAA), dat('hBBBB)};
      exp_l  = '{dat('hAAAA), dat('hCCCC)};
`else
      exp_tx = '{'h55, 'h55, 'h10, 'h11};
      beats  = '{dat('hAAAA), dat('hBBBB), dat('hCCCC), dat('hDDDD)};
      exp_k  = '{dat('hAAAA), dat('hCCCC)};
      exp_l  = '{dat('hBBBB), dat('hDDDD)};
`endif
      check("eq tx count", got_tx.size(), exp_tx.size());
      foreach (exp_tx[i]) if (i < got_tx.size()) check($sformatf("eq tx%0d addr", i), got_tx[i], exp_tx[i]);
      check("eq outstanding", outstanding, 4'd2);
      for (int c = 0; c < beats.size() + 3; c++) begin
         @(negedge clk);
         pair_valid     = 1'b0;
         io_rx_rd_valid = (c < beats.size());
         io_rx_data     = (c < beats.size()) ? beats[c] : '0;
         @(posedge clk); #1;
         if (resp_valid) begin
            got_k.push_back(resp_data_k);
            got_l.push_back(resp_data_l);
         end
      end
      check("eq resp count", got_k.size(), exp_k.size());
      foreach (exp_k[i]) begin
         if (i < got_k.size()) begin
            check($sformatf("eq resp%0d k", i), got_k[i], exp_k[i]);
            check($sformatf("eq resp%0d l", i), got_l[i], exp_l[i]);
         end
      end
      check("eq out drained", outstanding, 4'd0);
      check("eq no orphan", err_orphan, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
